// File: rtl/lock_code_sender_if.sv
// Handshake and button bundle between a code-entry source and the lock it drives.
// The master side is the requester/lock model; the slave side is lock_code_sender.
interface lock_code_sender_if #(
    parameter int unsigned CODE_LEN = 5
) ();
    logic                start;
    logic [CODE_LEN-1:0] code;
    logic                unlock;
    logic                btn_0;
    logic                btn_1;
    logic                busy;
    logic                done;
    logic                pass;

    modport master (
        output start, code, unlock,
        input  btn_0, btn_1, busy, done, pass
    );

    modport slave (
        input  start, code, unlock,
        output btn_0, btn_1, busy, done, pass
    );
endinterface

// File: rtl/lock_code_sender.sv
// Sends a code word MSB first as timed btn_0/btn_1 presses, then watches unlock for a
// bounded window and reports pass/fail with a one-cycle done pulse.
module lock_code_sender #(
    parameter int unsigned CODE_LEN     = 5,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 10,
    parameter int unsigned UNLOCK_WAIT  = 16
) (
    input logic                clk,
    input logic                btn_reset,
    lock_code_sender_if.slave  bus
);
    localparam int unsigned MaxPg  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCnt = (MaxPg > UNLOCK_WAIT) ? MaxPg : UNLOCK_WAIT;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast  = CntW'(UNLOCK_WAIT - 1);
    localparam logic [IdxW-1:0] IdxFirst  = IdxW'(CODE_LEN - 1);

    typedef enum logic [2:0] {StIdle, StPress, StGap, StWait, StDone} state_e;

    state_e              r_state, w_state_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic [IdxW-1:0]     r_idx, w_idx_nxt;
    logic [CODE_LEN-1:0] r_shift, w_shift_nxt;
    logic                r_pass, w_pass_nxt;
    logic                r_btn_0, r_btn_1, r_busy, r_done;
    logic [CODE_LEN-1:0] w_code;

    assign w_code = bus.code;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pass_nxt  = r_pass;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_nxt = StPress;
                    w_shift_nxt = w_code;
                    w_pass_nxt  = 1'b0;
                    w_idx_nxt   = IdxFirst;
                    w_cnt_nxt   = '0;
                end
            end
            StPress: begin
                if (r_cnt == PulseLast) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_idx == '0) ? StWait : StGap;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == GapLast) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx - 1'b1;
                    w_shift_nxt = r_shift << 1;
                    w_state_nxt = StPress;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StWait: begin
                // A hit in the final window cycle still counts as a pass.
                if (bus.unlock) begin
                    w_pass_nxt  = 1'b1;
                    w_state_nxt = StDone;
                end else if (r_cnt == WaitLast) begin
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (btn_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_pass  <= 1'b0;
            r_btn_0 <= 1'b0;
            r_btn_1 <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_pass  <= w_pass_nxt;
            r_btn_0 <= (w_state_nxt == StPress) && !w_shift_nxt[CODE_LEN-1];
            r_btn_1 <= (w_state_nxt == StPress) &&  w_shift_nxt[CODE_LEN-1];
            r_busy  <= (w_state_nxt != StIdle);
            r_done  <= (w_state_nxt == StDone);
        end
    end

    assign bus.btn_0 = r_btn_0;
    assign bus.btn_1 = r_btn_1;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.pass  = r_pass;
endmodule

// File: tb/tb_lock_code_sender.sv
// Randomized bench for lock_code_sender: two parameterisations, each checked cycle by cycle
// against an arithmetic model of the press schedule and unlock window.
module tb_lock_code_sender;
    localparam int unsigned CLA = 5, PA = 1, GA = 10, UWA = 16;
    localparam int unsigned CLB = 3, PB = 3, GB = 2, UWB = 4;

    logic clk = 1'b0;
    logic btn_reset;
    always #5 clk = ~clk;

    lock_code_sender_if #(.CODE_LEN(CLA)) bus_a ();
    lock_code_sender_if #(.CODE_LEN(CLB)) bus_b ();

    lock_code_sender #(
        .CODE_LEN(CLA), .PULSE_CYCLES(PA), .GAP_CYCLES(GA), .UNLOCK_WAIT(UWA)
    ) u_dut_a (
        .clk(clk), .btn_reset(btn_reset), .bus(bus_a.slave)
    );

    lock_code_sender #(
        .CODE_LEN(CLB), .PULSE_CYCLES(PB), .GAP_CYCLES(GB), .UNLOCK_WAIT(UWB)
    ) u_dut_b (
        .clk(clk), .btn_reset(btn_reset), .bus(bus_b.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed as {btn_0, btn_1, busy, done, pass}
    function automatic logic [31:0] observe(input bit sel);
        if (sel) return {27'b0, bus_b.btn_0, bus_b.btn_1, bus_b.busy, bus_b.done, bus_b.pass};
        return {27'b0, bus_a.btn_0, bus_a.btn_1, bus_a.busy, bus_a.done, bus_a.pass};
    endfunction

    task automatic drive(input bit sel, input bit st, input logic [7:0] c, input bit ul);
        if (sel) begin
            bus_b.start  = st;
            bus_b.code   = c[CLB-1:0];
            bus_b.unlock = ul;
        end else begin
            bus_a.start  = st;
            bus_a.code   = c[CLA-1:0];
            bus_a.unlock = ul;
        end
    endtask

    // Expected outputs k cycles after the accepting edge, from the published timing rules.
    function automatic logic [31:0] expected(input int k, input int cl, input int p, input int g,
                                             input int d, input bit passed,
                                             input logic [7:0] c);
        int l, j, r;
        logic b0, b1;
        l  = 1 + cl * p + (cl - 1) * g;
        b0 = 1'b0;
        b1 = 1'b0;
        if (k >= 1 && k < l) begin
            j = (k - 1) / (p + g);
            r = (k - 1) % (p + g);
            if (r < p) begin
                if (c[cl-1-j]) b1 = 1'b1;
                else           b0 = 1'b1;
            end
        end
        return {27'b0, b0, b1, (k >= 1 && k <= d), (k == d), (passed && k >= d)};
    endfunction

    // One attempt: unlock high for offsets [us, us+ul), start re-pulsed at offset inj,
    // optional reset asserted during offset rst_at.
    task automatic attempt(input bit sel, input logic [7:0] c, input int us, input int ul,
                           input int inj, input int rst_at, input string name);
        int cl, p, g, uw, l, d;
        bit passed, u;
        logic [7:0] rc;
        cl = sel ? CLB : CLA;
        p  = sel ? PB  : PA;
        g  = sel ? GB  : GA;
        uw = sel ? UWB : UWA;
        l  = 1 + cl * p + (cl - 1) * g;
        passed = 1'b0;
        d = l + uw;
        for (int x = l; x < l + uw; x++) begin
            if (ul > 0 && x >= us && x < us + ul) begin
                passed = 1'b1;
                d = x + 1;
                break;
            end
        end
        @(negedge clk);
        drive(sel, 1'b1, c, 1'b0);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            if (rst_at > 0 && k == rst_at + 1) begin
                check_eq({name, " after reset"}, observe(sel), 32'd0);
                btn_reset = 1'b0;
                drive(sel, 1'b0, 8'd0, 1'b0);
                return;
            end
            check_eq(name, observe(sel), expected(k, cl, p, g, d, passed, c));
            rc = 8'($urandom);
            u  = (ul > 0 && k >= us && k < us + ul);
            drive(sel, (k == inj), rc, u);
            if (k == rst_at) btn_reset = 1'b1;
        end
        drive(sel, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] c;
        int us, ul, inj;
        btn_reset = 1'b1;
        drive(1'b0, 1'b1, 8'h1f, 1'b0);
        drive(1'b1, 1'b1, 8'h07, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("reset a", observe(1'b0), 32'd0);
            check_eq("reset b", observe(1'b1), 32'd0);
        end
        btn_reset = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        check_eq("idle after reset", observe(1'b0), 32'd0);

        attempt(1'b0, 8'b11001, 48, 3, 0, 0, "correct code");
        attempt(1'b0, 8'b00000, 0, 0, 0, 0, "wrong code");
        attempt(1'b0, 8'b11001, 48, 3, 20, 0, "start while busy");
        attempt(1'b0, 8'b11001, 20, 20, 0, 0, "early unlock dropped");
        attempt(1'b0, 8'b10110, 40, 7, 0, 0, "unlock spans window start");
        attempt(1'b0, 8'b01101, 61, 1, 0, 0, "unlock last window cycle");
        attempt(1'b0, 8'b11001, 0, 0, 0, 23, "reset mid attempt");
        @(negedge clk);
        attempt(1'b0, 8'b11001, 50, 1, 0, 0, "after reset");
        attempt(1'b1, 8'b101, 0, 0, 0, 0, "sweep 101");
        attempt(1'b1, 8'b010, 15, 2, 5, 0, "sweep 010");

        for (int n = 0; n < 24; n++) begin
            c   = 8'($urandom);
            us  = 40 + int'($urandom_range(0, 24));
            ul  = int'($urandom_range(0, 6));
            inj = int'($urandom_range(0, 46));
            attempt(1'b0, c, us, ul, inj, 0, "random a");
        end
        for (int n = 0; n < 12; n++) begin
            c   = 8'($urandom);
            us  = 10 + int'($urandom_range(0, 9));
            ul  = int'($urandom_range(0, 3));
            inj = int'($urandom_range(0, 14));
            attempt(1'b1, c, us, ul, inj, 0, "random b");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
